// File: rtl/his_peak_reader.sv
// his_peak_reader: scans streamed CH/FH histogram frames and registers the peak bin per type.
module his_peak_reader #(
    parameter int NP       = 8,
    parameter int PEAK_MAX = 8,
    parameter int NB       = 16,
    parameter int MIN_PEAK = 1
) (
    input  logic                clk,
    input  logic                res,
    input  logic [1:0]          status,
    input  logic [PEAK_MAX-1:0] bin_counts,
    input  logic [NP-1:0]       addr,
    output logic [NP-1:0]       peak_ch,
    output logic [PEAK_MAX-1:0] peak_ch_cnt,
    output logic [NP-1:0]       peak_fh,
    output logic [PEAK_MAX-1:0] peak_fh_cnt,
    output logic                ch_valid,
    output logic                fh_valid,
    output logic                seq_err,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, SCAN_CH, SCAN_FH} state_t;

    localparam logic [PEAK_MAX-1:0] MIN_P = PEAK_MAX'(MIN_PEAK);
    localparam logic [NP:0]         NB_L  = (NP+1)'(NB);

    state_t              state_q, state_d;
    logic [PEAK_MAX-1:0] run_max_q, run_max_d, peak_ch_cnt_q, peak_ch_cnt_d, peak_fh_cnt_q, peak_fh_cnt_d;
    logic [NP-1:0]       run_idx_q, run_idx_d, exp_q, exp_d, peak_ch_q, peak_ch_d, peak_fh_q, peak_fh_d;
    logic                ch_valid_q, ch_valid_d, fh_valid_q, fh_valid_d, seq_err_q, seq_err_d;

    logic                code_ch, code_fh, active, start, scan, addr_ok, upd, done_ch, done_fh, found;
    logic [NP-1:0]       exp_now, base_idx;
    logic [PEAK_MAX-1:0] base_max;

    always_comb begin
        code_ch   = status == 2'b01;
        code_fh   = status == 2'b10;
        active    = (state_q == SCAN_CH && code_ch) || (state_q == SCAN_FH && code_fh);
        // a new frame starts from IDLE or directly when the other type's code appears
        start     = !active && (code_ch || code_fh);
        scan      = active || start;
        exp_now   = start ? NP'(1) : exp_q;
        base_max  = start ? '0 : run_max_q;
        base_idx  = start ? '0 : run_idx_q;
        addr_ok   = addr == exp_now && addr != '0 && {1'b0, addr} <= NB_L;
        upd       = scan && addr_ok && bin_counts > base_max;
        run_max_d = upd ? bin_counts : (scan ? base_max : '0);
        run_idx_d = upd ? addr : (scan ? base_idx : '0);
        exp_d     = scan ? addr + NP'(1) : exp_q;
        seq_err_d = seq_err_q || (scan && !addr_ok) || status == 2'b11;
        done_ch   = state_q == SCAN_CH && !active;
        done_fh   = state_q == SCAN_FH && !active;
        found     = run_max_q >= MIN_P;
        peak_ch_d     = done_ch ? (found ? run_idx_q : '0) : peak_ch_q;
        peak_ch_cnt_d = done_ch ? (found ? run_max_q : '0) : peak_ch_cnt_q;
        peak_fh_d     = done_fh ? (found ? run_idx_q : '0) : peak_fh_q;
        peak_fh_cnt_d = done_fh ? (found ? run_max_q : '0) : peak_fh_cnt_q;
        ch_valid_d    = done_ch;
        fh_valid_d    = done_fh;
        state_d       = code_ch ? SCAN_CH : code_fh ? SCAN_FH : IDLE;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= IDLE;
            run_max_q     <= '0;
            run_idx_q     <= '0;
            exp_q         <= '0;
            peak_ch_q     <= '0;
            peak_ch_cnt_q <= '0;
            peak_fh_q     <= '0;
            peak_fh_cnt_q <= '0;
            ch_valid_q    <= 1'b0;
            fh_valid_q    <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_max_q     <= run_max_d;
            run_idx_q     <= run_idx_d;
            exp_q         <= exp_d;
            peak_ch_q     <= peak_ch_d;
            peak_ch_cnt_q <= peak_ch_cnt_d;
            peak_fh_q     <= peak_fh_d;
            peak_fh_cnt_q <= peak_fh_cnt_d;
            ch_valid_q    <= ch_valid_d;
            fh_valid_q    <= fh_valid_d;
            seq_err_q     <= seq_err_d;
        end
    end

    assign peak_ch     = peak_ch_q;
    assign peak_ch_cnt = peak_ch_cnt_q;
    assign peak_fh     = peak_fh_q;
    assign peak_fh_cnt = peak_fh_cnt_q;
    assign ch_valid    = ch_valid_q;
    assign fh_valid    = fh_valid_q;
    assign seq_err     = seq_err_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_his_peak_reader.sv
// tb_his_peak_reader: two DUTs (MIN_PEAK 1 and 4) on one stream, checked against a frame-list model.
module tb_his_peak_reader;
    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [1:0] status = 2'b00;
    logic [7:0] bin_counts = '0;
    logic [7:0] addr = '0;
    logic [7:0] pch [2], pchc [2], pfh [2], pfhc [2];
    logic       chv [2], fhv [2], err [2], bsy [2];

    int tests = 0, fails = 0;
    bit chk_on = 0;

    // model state: current frame type (0 none), accepted bin counts/addrs, next legal address
    int ftype = 0, nexp = 1;
    int qc[$], qa[$];
    int e_pch [2], e_pchc [2], e_pfh [2], e_pfhc [2];
    int e_chv = 0, e_fhv = 0, e_err = 0, e_busy = 0;

    always #5 clk = ~clk;

    his_peak_reader #(.NP(8), .PEAK_MAX(8), .NB(16), .MIN_PEAK(1)) u1 (
        .clk(clk), .res(res), .status(status), .bin_counts(bin_counts), .addr(addr),
        .peak_ch(pch[0]), .peak_ch_cnt(pchc[0]), .peak_fh(pfh[0]), .peak_fh_cnt(pfhc[0]),
        .ch_valid(chv[0]), .fh_valid(fhv[0]), .seq_err(err[0]), .busy(bsy[0]));

    his_peak_reader #(.NP(8), .PEAK_MAX(8), .NB(16), .MIN_PEAK(4)) u2 (
        .clk(clk), .res(res), .status(status), .bin_counts(bin_counts), .addr(addr),
        .peak_ch(pch[1]), .peak_ch_cnt(pchc[1]), .peak_fh(pfh[1]), .peak_fh_cnt(pfhc[1]),
        .ch_valid(chv[1]), .fh_valid(fhv[1]), .seq_err(err[1]), .busy(bsy[1]));

    task automatic cmp(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic finish_frame();
        for (int k = 0; k < 2; k++) begin
            int mx = 0, ix = 0, minp = (k == 0) ? 1 : 4;
            foreach (qc[j]) if (qc[j] > mx) begin mx = qc[j]; ix = qa[j]; end
            if (mx < minp) begin mx = 0; ix = 0; end
            if (ftype == 1) begin e_pch[k] = ix; e_pchc[k] = mx; end
            else begin e_pfh[k] = ix; e_pfhc[k] = mx; end
        end
        if (ftype == 1) e_chv = 1; else e_fhv = 1;
        ftype = 0;
    endtask

    task automatic model(input int s, input int c, input int a, input bit r);
        e_chv = 0;
        e_fhv = 0;
        if (r) begin
            ftype = 0; e_err = 0;
            for (int k = 0; k < 2; k++) begin e_pch[k] = 0; e_pchc[k] = 0; e_pfh[k] = 0; e_pfhc[k] = 0; end
        end else begin
            if (ftype != 0 && s != ftype) finish_frame();
            if (s == 3) e_err = 1;
            if (s == 1 || s == 2) begin
                if (ftype == 0) begin ftype = s; qc.delete(); qa.delete(); nexp = 1; end
                if (a == nexp && a >= 1 && a <= 16) begin qc.push_back(c); qa.push_back(a); end
                else e_err = 1;
                nexp = a + 1;
            end
        end
        e_busy = (ftype != 0);
    endtask

    task automatic drive(input int s, input int c, input int a, input bit r);
        status = 2'(s); bin_counts = 8'(c); addr = 8'(a); res = r;
        @(posedge clk);
        #1;
        model(s, c, a, r);
    endtask

    always @(negedge clk) if (chk_on) begin
        for (int k = 0; k < 2; k++) begin
            cmp($sformatf("u%0d.peak_ch", k+1), int'(pch[k]), e_pch[k]);
            cmp($sformatf("u%0d.peak_ch_cnt", k+1), int'(pchc[k]), e_pchc[k]);
            cmp($sformatf("u%0d.peak_fh", k+1), int'(pfh[k]), e_pfh[k]);
            cmp($sformatf("u%0d.peak_fh_cnt", k+1), int'(pfhc[k]), e_pfhc[k]);
            cmp($sformatf("u%0d.ch_valid", k+1), int'(chv[k]), e_chv);
            cmp($sformatf("u%0d.fh_valid", k+1), int'(fhv[k]), e_fhv);
            cmp($sformatf("u%0d.seq_err", k+1), int'(err[k]), e_err);
            cmp($sformatf("u%0d.busy", k+1), int'(bsy[k]), e_busy);
        end
    end

    initial begin
        int c1[4] = '{3, 7, 2, 7};
        drive(0, 0, 0, 1);
        chk_on = 1;
        cmp("reset peak_ch", int'(pch[0]), 0);
        cmp("reset busy", int'(bsy[0]), 0);
        // 1: CH peak with tie keeps lowest address
        for (int i = 0; i < 4; i++) drive(1, c1[i], i + 1, 0);
        drive(0, 0, 0, 0);
        cmp("t1 ch_valid", int'(chv[0]), 1);
        cmp("t1 peak_ch", int'(pch[0]), 2);
        cmp("t1 peak_ch_cnt", int'(pchc[0]), 7);
        cmp("t1 peak_fh", int'(pfh[0]), 0);
        drive(0, 0, 0, 0);
        cmp("t1 ch_valid drop", int'(chv[0]), 0);
        // 2: all-zero FH frame
        for (int i = 1; i <= 3; i++) drive(2, 0, i, 0);
        drive(0, 0, 0, 0);
        cmp("t2 fh_valid", int'(fhv[0]), 1);
        cmp("t2 peak_fh", int'(pfh[0]), 0);
        cmp("t2 peak_ch kept", int'(pch[0]), 2);
        // 3: back-to-back CH then FH
        drive(1, 1, 1, 0);
        drive(1, 5, 2, 0);
        drive(2, 9, 1, 0);
        cmp("t3 ch_valid", int'(chv[0]), 1);
        cmp("t3 peak_ch_cnt", int'(pchc[0]), 5);
        cmp("t3 busy", int'(bsy[0]), 1);
        drive(2, 4, 2, 0);
        cmp("t3 busy2", int'(bsy[0]), 1);
        drive(0, 0, 0, 0);
        cmp("t3 fh_valid", int'(fhv[0]), 1);
        cmp("t3 peak_fh", int'(pfh[0]), 1);
        cmp("t3 peak_fh_cnt", int'(pfhc[0]), 9);
        // 4: address skip excluded, sticky error
        drive(1, 2, 1, 0);
        cmp("t4 err before", int'(err[0]), 0);
        drive(1, 8, 3, 0);
        cmp("t4 seq_err", int'(err[0]), 1);
        drive(1, 1, 4, 0);
        drive(0, 0, 0, 0);
        cmp("t4 peak_ch", int'(pch[0]), 1);
        cmp("t4 peak_ch_cnt", int'(pchc[0]), 2);
        drive(1, 3, 1, 0);
        drive(0, 0, 0, 0);
        cmp("t4 err sticky", int'(err[0]), 1);
        // 5: reset mid-frame
        drive(1, 9, 1, 0);
        drive(1, 9, 2, 1);
        cmp("t5 ch_valid", int'(chv[0]), 0);
        cmp("t5 peak_ch", int'(pch[0]), 0);
        cmp("t5 seq_err", int'(err[0]), 0);
        drive(1, 4, 1, 0);
        drive(1, 6, 2, 0);
        drive(0, 0, 0, 0);
        cmp("t5 peak_ch after", int'(pch[0]), 2);
        cmp("t5 peak_ch_cnt after", int'(pchc[0]), 6);
        // 6: MIN_PEAK=4 on u2
        drive(2, 3, 1, 0); drive(2, 1, 2, 0); drive(2, 2, 3, 0);
        drive(0, 0, 0, 0);
        cmp("t6 u2 fh_valid", int'(fhv[1]), 1);
        cmp("t6 u2 peak_fh", int'(pfh[1]), 0);
        cmp("t6 u1 peak_fh", int'(pfh[0]), 1);
        drive(2, 3, 1, 0); drive(2, 4, 2, 0); drive(2, 2, 3, 0);
        drive(0, 0, 0, 0);
        cmp("t6 u2 peak_fh b", int'(pfh[1]), 2);
        cmp("t6 u2 peak_fh_cnt b", int'(pfhc[1]), 4);
        // randomized frames
        for (int f = 0; f < 200; f++) begin
            int typ = $urandom_range(1, 2), len = $urandom_range(1, 18), g;
            if ($urandom_range(0, 7) == 0) drive(0, 0, 0, 1);
            for (int i = 1; i <= len; i++) begin
                int a = i;
                if ($urandom_range(0, 15) == 0) a = $urandom_range(0, 20);
                drive(typ, $urandom_range(0, 15), a, $urandom_range(0, 63) == 0);
            end
            g = $urandom_range(0, 5);
            if (g == 1) drive(3, 0, 0, 0);
            for (int i = 1; i < g; i++) drive(0, 0, 0, 0);
        end
        drive(0, 0, 0, 0);
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/his_peak_reader.md
Name: his_peak_reader

Overview:
- Consumer end of the histogram read-out stream. The histogram builder drives this stream: one bin per cycle with a status code, bin index and bin count.
- Scans each streamed coarse histogram (CH) and fine histogram (FH) frame and finds the peak bin.
- Registers the peak bin index and count per histogram type and raises a one-cycle valid pulse for each completed frame.
- Feeds the algebraic threshold/delta block downstream.

Parameters:
- NP, 8: bin address width. Address 0 is never a legal bin.
- PEAK_MAX, 8: bin count width.
- NB, 16: maximum number of bins per frame. Legal addresses are 1..NB.
- MIN_PEAK, 1: minimum count accepted as a peak.

Ports:
- clk  in  1  system clock, rising edge.
- res  in  1  synchronous, active-high reset.
- status  in  2  stream status: 00 idle, 01 CH bin valid, 10 FH bin valid, 11 reserved.
- bin_counts  in  PEAK_MAX  count of the current bin.
- addr  in  NP  index of the current bin.
- peak_ch  out  NP  CH peak bin index; 0 = no peak.
- peak_ch_cnt  out  PEAK_MAX  CH peak count.
- peak_fh  out  NP  FH peak bin index; 0 = no peak.
- peak_fh_cnt  out  PEAK_MAX  FH peak count.
- ch_valid  out  1  one-cycle pulse: CH result updated.
- fh_valid  out  1  one-cycle pulse: FH result updated.
- seq_err  out  1  sticky stream protocol error.
- busy  out  1  high while a frame is being scanned.

Behaviour:
- All inputs are sampled on the rising edge of clk.
- res has priority over every other event.
  - On res: every output goes to 0, the FSM goes to IDLE, and the running max/index clear.
  - No valid pulse is generated for a frame aborted by res.
- FSM states: IDLE, SCAN_CH, SCAN_FH. busy = (state != IDLE).
- IDLE transitions:
  - status 01 -> SCAN_CH.
  - status 10 -> SCAN_FH.
  - status 00 -> stay in IDLE.
  - status 11 -> seq_err=1, stay in IDLE.
- Frame start: the first edge that samples the frame's status code.
  - run_max and run_idx are cleared to 0 before the first bin is compared.
  - The first bin is compared in that same cycle.
- Scanning: each edge that samples the active code compares one bin.
  - If bin_counts > run_max (strictly greater): run_max <= bin_counts, run_idx <= addr.
  - Ties therefore keep the lowest address.
  - Bins with count 0 never update, so an all-zero frame leaves run_idx = 0.
- Frame end: edge E, the first edge sampling a status other than the active code.
  - If run_max >= MIN_PEAK: peak_x <= run_idx and peak_x_cnt <= run_max. Otherwise both <= 0.
  - x_valid is high for exactly the one cycle after E.
  - Latency: result is visible one cycle after the last bin was sampled.
- Back-to-back frames: if status at E is the other type's code (01<->10):
  - The new scan starts at E and compares its first bin at E.
  - The finishing frame's valid pulse is still issued.
  - No idle cycle is required.
- Status 11 sampled at E: terminate the current frame normally, set seq_err, go to IDLE.
- Address checking within a frame:
  - The first bin must have addr == 1.
  - Each following bin must have addr == previous addr + 1.
  - Any addr == 0 or addr > NB is an error.
  - On violation: seq_err <= 1 and the offending bin is excluded from comparison.
  - Scanning continues, and the expected next address becomes offending addr + 1.
- A frame longer than NB bins raises seq_err on bin NB+1 via the addr > NB rule.
- A frame shorter than NB bins is legal.
- seq_err is sticky until res.
- Result holding:
  - peak_ch/peak_ch_cnt hold until the next CH frame completes or res.
  - peak_fh/peak_fh_cnt hold likewise for FH frames.
  - One type's results are never modified by the other type's frames.
- Arithmetic: all comparisons are unsigned, PEAK_MAX wide. No saturation is needed because counts are passed through.

Test Plan:
1. res, then CH frame, status=01, addr 1..4, counts 3,7,2,7, then status=00 -> one cycle after the last bin: ch_valid=1 for one cycle, peak_ch=2, peak_ch_cnt=7. FH outputs stay 0. seq_err=0.
2. FH frame, addr 1..3, counts 0,0,0 -> fh_valid pulse, peak_fh=0, peak_fh_cnt=0. CH results from scenario 1 unchanged.
3. CH frame addr 1..2 (counts 1,5) immediately followed by FH frame addr 1..2 (counts 9,4), no idle cycle -> ch_valid at the switch (peak_ch=2, cnt=5); fh_valid two cycles later (peak_fh=1, cnt=9); busy stays high throughout.
4. CH frame with addr sequence 1,3,4 (counts 2,8,1) -> seq_err=1 at the addr-3 edge and held; peak_ch=1, cnt=2 (bin 3 excluded); seq_err stays 1 through later clean frames until res.
5. res=1 during the second bin of a CH frame -> next cycle all outputs 0, no ch_valid; a following clean CH frame (counts 4,6) gives peak_ch=2, cnt=6.
6. MIN_PEAK=4, FH frame counts 3,1,2 -> fh_valid pulse, peak_fh=0, peak_fh_cnt=0. Repeat with counts 3,4,2 -> peak_fh=2, cnt=4.
